mel_filter_accum: RTL and testbench

//  Mel filterbank stage of the MFCC chain. Takes power-spectrum bins from the FFT

---
 rtl/mel_filter_accum.sv | 159 +++++++++++++++
 tb/tb_mel_filter_accum.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mel_filter_accum.sv
// Mel filterbank accumulator: weights each power bin into up to two adjacent triangular
// filters using a two-word-per-bin coefficient ROM, then streams the filter energies.
module mel_filter_accum #(
   parameter int unsigned PWR_W    = 32,
   parameter int unsigned ACC_W    = 48,
   parameter int unsigned NUM_FILT = 26,
   parameter int unsigned N_BIN    = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bin_valid,
   output logic             bin_ready,
   input  logic [PWR_W-1:0] bin_data,
   input  logic             bin_last,
   output logic [8:0]       rom_addr,
   input  logic [7:0]       rom_data,
   output logic             mel_valid,
   input  logic             mel_ready,
   output logic [ACC_W-1:0] mel_data,
   output logic [4:0]       mel_idx,
   output logic             busy
);

   localparam int unsigned PROD_W = PWR_W + 8;
   localparam int unsigned K_W    = 8;
   localparam int unsigned IDX_W  = 5;

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR_W, S_GET_F, S_GET_W, S_MAC, S_OUT
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [K_W-1:0]     r_k, w_k_nxt;
   logic [IDX_W-1:0]   r_j, w_j_nxt;
   logic [PWR_W-1:0]   r_p;
   logic               r_last;
   logic [7:0]         r_f, r_w;
   logic [8:0]         w_addr_nxt;
   logic               w_accept, w_out_hs;
   logic [PROD_W-1:0]  w_prod_hi, w_prod_lo;
   logic [ACC_W-1:0]   r_acc     [NUM_FILT];
   logic [ACC_W-1:0]   w_acc_nxt [NUM_FILT];
   logic [ACC_W-1:0]   w_mel_nxt;

   function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                input logic [PROD_W-1:0] b);
      logic [ACC_W:0] s;
      s = {1'b0, a} + (ACC_W+1)'(b);
      return s[ACC_W] ? '1 : s[ACC_W-1:0];
   endfunction

   // Upper filter gets p*w, the filter below it gets the complementary p*(255-w)
   assign w_prod_hi = PROD_W'(r_p) * PROD_W'(r_w);
   assign w_prod_lo = PROD_W'(r_p) * PROD_W'(8'd255 - r_w);

   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_k_nxt     = r_k;
      w_j_nxt     = r_j;
      w_addr_nxt  = rom_addr;
      w_accept    = 1'b0;
      w_out_hs    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bin_valid && bin_ready) begin
               w_accept    = 1'b1;
               w_addr_nxt  = {r_k, 1'b0};
               w_state_nxt = S_ADDR_W;
            end
         end
         S_ADDR_W: begin
            w_addr_nxt  = {r_k, 1'b1};
            w_state_nxt = S_GET_F;
         end
         S_GET_F: w_state_nxt = S_GET_W;
         S_GET_W: w_state_nxt = S_MAC;
         S_MAC: begin
            if (r_last) begin
               w_j_nxt     = '0;
               w_state_nxt = S_OUT;
            end else begin
               w_k_nxt     = r_k + K_W'(1);
               w_state_nxt = S_IDLE;
            end
         end
         S_OUT: begin
            if (mel_valid && mel_ready) begin
               w_out_hs = 1'b1;
               if (r_j == IDX_W'(NUM_FILT - 1)) begin
                  w_k_nxt     = '0;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_j_nxt = r_j + IDX_W'(1);
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Next accumulator image: MAC update, or clear of the filter just handed off
   always_comb begin
      for (int i = 0; i < NUM_FILT; i++) begin
         w_acc_nxt[i] = r_acc[i];
         if (r_state == S_MAC) begin
            if (r_f == 8'(i))     w_acc_nxt[i] = sat_add(r_acc[i], w_prod_hi);
            if (r_f == 8'(i + 1)) w_acc_nxt[i] = sat_add(r_acc[i], w_prod_lo);
         end
         if (w_out_hs && (r_j == IDX_W'(i))) w_acc_nxt[i] = '0;
      end
   end

   always_comb begin
      w_mel_nxt = '0;
      for (int i = 0; i < NUM_FILT; i++) begin
         if (w_j_nxt == IDX_W'(i)) w_mel_nxt = w_acc_nxt[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_k       <= '0;
         r_j       <= '0;
         r_p       <= '0;
         r_last    <= 1'b0;
         r_f       <= '0;
         r_w       <= '0;
         rom_addr  <= '0;
         bin_ready <= 1'b0;
         busy      <= 1'b0;
         mel_valid <= 1'b0;
         mel_idx   <= '0;
         mel_data  <= '0;
         for (int i = 0; i < NUM_FILT; i++) r_acc[i] <= '0;
      end else begin
         r_k      <= w_k_nxt;
         r_j      <= w_j_nxt;
         rom_addr <= w_addr_nxt;
         if (w_accept) begin
            r_p    <= bin_data;
            r_last <= bin_last | (r_k == K_W'(N_BIN - 1));
         end
         if (r_state == S_GET_F) r_f <= rom_data;
         if (r_state == S_GET_W) r_w <= rom_data;
         for (int i = 0; i < NUM_FILT; i++) r_acc[i] <= w_acc_nxt[i];
         bin_ready <= (w_state_nxt == S_IDLE);
         busy      <= (w_state_nxt != S_IDLE);
         mel_valid <= (w_state_nxt == S_OUT);
         mel_idx   <= (w_state_nxt == S_OUT) ? w_j_nxt   : '0;
         mel_data  <= (w_state_nxt == S_OUT) ? w_mel_nxt : '0;
      end
   end

endmodule

// File: tb/tb_mel_filter_accum.sv
// Directed bench for mel_filter_accum: ROM model, hand-computed filter energies,
// a narrow-accumulator twin instance to exercise saturation.
module tb_mel_filter_accum;
   localparam int unsigned NF    = 26;
   localparam int unsigned SAT_W = 41;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, bin_valid, bin_last, mel_ready;
   logic [31:0] bin_data;
   logic [7:0]  rom_data;
   logic        bin_ready, mel_valid, busy;
   logic [8:0]  rom_addr;
   logic [47:0] mel_data;
   logic [4:0]  mel_idx;
   logic             s_bin_ready, s_mel_valid, s_busy;
   logic [8:0]       s_rom_addr;
   logic [SAT_W-1:0] s_mel_data;
   logic [4:0]       s_mel_idx;

   logic [7:0]       rom [512];
   logic [47:0]      exp_acc [NF];
   logic [SAT_W-1:0] exp_s [NF];
   int n_err = 0;
   int n_chk = 0;

   mel_filter_accum dut (
      .clk(clk), .rst(rst), .bin_valid(bin_valid), .bin_ready(bin_ready),
      .bin_data(bin_data), .bin_last(bin_last), .rom_addr(rom_addr), .rom_data(rom_data),
      .mel_valid(mel_valid), .mel_ready(mel_ready), .mel_data(mel_data),
      .mel_idx(mel_idx), .busy(busy));

   // Same stimulus, 41-bit accumulators so three full-scale bins overflow
   mel_filter_accum #(.ACC_W(SAT_W)) dut_s (
      .clk(clk), .rst(rst), .bin_valid(bin_valid), .bin_ready(s_bin_ready),
      .bin_data(bin_data), .bin_last(bin_last), .rom_addr(s_rom_addr), .rom_data(rom_data),
      .mel_valid(s_mel_valid), .mel_ready(mel_ready), .mel_data(s_mel_data),
      .mel_idx(s_mel_idx), .busy(s_busy));

   always_ff @(posedge clk) rom_data <= rom[rom_addr];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_rom();
      for (int k = 0; k < 256; k++) begin
         rom[2*k]   = 8'hFF;
         rom[2*k+1] = 8'h00;
      end
   endtask

   task automatic clear_exp();
      for (int j = 0; j < NF; j++) begin
         exp_acc[j] = '0;
         exp_s[j]   = '0;
      end
   endtask

   task automatic send_bin(input logic [31:0] p, input logic last);
      int t;
      bin_valid = 1'b1;
      bin_data  = p;
      bin_last  = last;
      t = 0;
      while (!bin_ready && t < 100) begin
         tick();
         t++;
      end
      chk("accept_wait", 64'(bin_ready), 64'd1);
      tick();
      bin_valid = 1'b0;
      bin_last  = 1'b0;
   endtask

   task automatic read_frame(input bit bp, input bit chk_s);
      int t;
      for (int j = 0; j < NF; j++) begin
         t = 0;
         while (!mel_valid && t < 100) begin
            tick();
            t++;
         end
         chk($sformatf("mel_valid%0d", j), 64'(mel_valid), 64'd1);
         chk($sformatf("mel_idx%0d", j), 64'(mel_idx), 64'(j));
         chk($sformatf("mel_data%0d", j), 64'(mel_data), 64'(exp_acc[j]));
         if (chk_s) begin
            chk($sformatf("sat_data%0d", j), 64'(s_mel_data), 64'(exp_s[j]));
            chk($sformatf("sat_idx%0d", j), 64'(s_mel_idx), 64'(j));
            chk($sformatf("sat_valid%0d", j), 64'(s_mel_valid), 64'd1);
         end
         if (bp) begin
            mel_ready = 1'b0;
            repeat (2) begin
               tick();
               chk($sformatf("stall_data%0d", j), 64'(mel_data), 64'(exp_acc[j]));
               chk($sformatf("stall_idx%0d", j), 64'(mel_idx), 64'(j));
            end
         end
         mel_ready = 1'b1;
         tick();
         mel_ready = 1'b0;
      end
      chk("post_frame_valid", 64'(mel_valid), 64'd0);
      chk("post_frame_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      rst = 1'b0; bin_valid = 1'b0; bin_last = 1'b0; bin_data = '0; mel_ready = 1'b0;
      clear_rom();
      clear_exp();

      // Reset state
      repeat (3) tick();
      chk("rst_bin_ready", 64'(bin_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_mel_valid", 64'(mel_valid), 64'd0);
      chk("rst_mel_data", 64'(mel_data), 64'd0);
      chk("rst_mel_idx", 64'(mel_idx), 64'd0);
      chk("rst_rom_addr", 64'(rom_addr), 64'd0);
      chk("rst_sat_busy", 64'(s_busy), 64'd0);
      rst = 1'b1;
      tick();
      chk("rel_bin_ready", 64'(bin_ready), 64'd1);
      chk("rel_busy", 64'(busy), 64'd0);
      chk("rel_sat_bin_ready", 64'(s_bin_ready), 64'd1);
      chk("rel_sat_rom_addr", 64'(s_rom_addr), 64'd0);

      // Single bin f=2 w=64 p=1000: acc[2]=64000, acc[1]=1000*191
      rom[0] = 8'd2; rom[1] = 8'd64;
      send_bin(32'd1000, 1'b1);
      chk("single_busy", 64'(busy), 64'd1);
      chk("single_ready_low", 64'(bin_ready), 64'd0);
      chk("single_addr_f", 64'(rom_addr), 64'h000);
      tick();
      chk("single_addr_w", 64'(rom_addr), 64'h001);
      clear_exp();
      exp_acc[2] = 48'd64000;
      exp_acc[1] = 48'd191000;
      read_frame(1'b0, 1'b0);

      // Split weight f=1 w=200 p=10
      clear_rom();
      rom[0] = 8'd1; rom[1] = 8'd200;
      send_bin(32'd10, 1'b1);
      clear_exp();
      exp_acc[1] = 48'd2000;
      exp_acc[0] = 48'd550;
      read_frame(1'b0, 1'b0);

      // Out-of-range: f=FF contributes nothing, f=NF feeds only the top filter
      clear_rom();
      rom[0] = 8'hFF; rom[1] = 8'h80;
      rom[2] = 8'(NF); rom[3] = 8'd0;
      send_bin(32'd4, 1'b0);
      send_bin(32'd4, 1'b1);
      clear_exp();
      exp_acc[NF-1] = 48'd1020;
      read_frame(1'b0, 1'b0);

      // Frame-length wrap: no bin_last, frame closes on bin 255
      clear_rom();
      rom[0] = 8'd0; rom[1] = 8'd255;
      rom[510] = 8'd3; rom[511] = 8'd1;
      send_bin(32'd1, 1'b0);
      for (int k = 1; k < 255; k++) send_bin(32'(k), 1'b0);
      repeat (6) tick();
      chk("wrap_no_output_yet", 64'(mel_valid), 64'd0);
      chk("wrap_still_ready", 64'(bin_ready), 64'd1);
      send_bin(32'd2, 1'b0);
      clear_exp();
      exp_acc[0] = 48'd255;
      exp_acc[3] = 48'd2;
      exp_acc[2] = 48'd508;
      read_frame(1'b0, 1'b0);

      // Next frame restarts at bin 0
      clear_rom();
      rom[0] = 8'd5; rom[1] = 8'd10;
      send_bin(32'd3, 1'b1);
      chk("restart_addr", 64'(rom_addr), 64'h000);
      clear_exp();
      exp_acc[5] = 48'd30;
      exp_acc[4] = 48'd735;
      read_frame(1'b0, 1'b0);

      // Backpressure plus saturation in the 41-bit twin
      clear_rom();
      for (int k = 0; k < 3; k++) begin
         rom[2*k] = 8'd0; rom[2*k+1] = 8'd255;
      end
      send_bin(32'hFFFF_FFFF, 1'b0);
      send_bin(32'hFFFF_FFFF, 1'b0);
      send_bin(32'hFFFF_FFFF, 1'b1);
      clear_exp();
      exp_acc[0] = 48'd3 * 48'd255 * 48'hFFFF_FFFF;
      exp_s[0]   = '1;
      read_frame(1'b1, 1'b1);

      // Reset in S_MAC discards the partial frame
      clear_rom();
      rom[0] = 8'd10; rom[1] = 8'd100;
      rom[2] = 8'd10; rom[3] = 8'd100;
      send_bin(32'd7, 1'b0);
      send_bin(32'd7, 1'b0);
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_ready", 64'(bin_ready), 64'd0);
      chk("midrst_valid", 64'(mel_valid), 64'd0);
      tick();
      rst = 1'b1;
      tick();
      chk("midrst_rel_ready", 64'(bin_ready), 64'd1);
      clear_rom();
      rom[0] = 8'd12; rom[1] = 8'd0;
      send_bin(32'd1, 1'b1);
      chk("midrst_addr", 64'(rom_addr), 64'h000);
      clear_exp();
      exp_acc[11] = 48'd255;
      read_frame(1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
